// File: rtl/id_operand_stage.sv
// ID-stage operand formatter: RV32I immediate decode, operand/store-data selection, two-entry skid buffer.
// Optional EX/MEM forwarding onto rs1/rs2 is enabled by defining ID_OPERAND_FWD_EN.
module id_operand_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] reg1_data,
    input  logic [XLEN-1:0] reg2_data,
    input  logic            fwd_valid,
    input  logic [4:0]      fwd_rd,
    input  logic [XLEN-1:0] fwd_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] operand1,
    output logic [XLEN-1:0] operand2,
    output logic [XLEN-1:0] s_data,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] sdata;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } entry_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    state_t          state_r, state_next_s;
    logic            in_ready_r, out_valid_r;
    logic            accept_s, load_main_in_s, load_main_skid_s, load_skid_s;
    entry_t          main_r, skid_r, fmt_s;
    logic [6:0]      opcode_s;
    logic [XLEN-1:0] rs1_val_s, rs2_val_s;
    logic [XLEN-1:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;

    assign opcode_s = in_instr[6:0];
    assign imm_i_s  = sext32({{20{in_instr[31]}}, in_instr[31:20]});
    assign imm_s_s  = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
    assign imm_b_s  = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0});
    assign imm_u_s  = sext32({in_instr[31:12], 12'h000});
    assign imm_j_s  = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0});

`ifdef ID_OPERAND_FWD_EN
    // x0 is never forwarded: it reads as zero regardless of what EX/MEM claims to write.
    assign rs1_val_s = (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == in_instr[19:15])) ? fwd_data : reg1_data;
    assign rs2_val_s = (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == in_instr[24:20])) ? fwd_data : reg2_data;
`else
    logic fwd_unused_s;
    assign fwd_unused_s = ^{fwd_valid, fwd_rd, fwd_data};
    assign rs1_val_s    = reg1_data;
    assign rs2_val_s    = reg2_data;
`endif

    // Operand, store-data and immediate selection per opcode.
    always_comb begin
        fmt_s.op1     = {XLEN{1'b0}};
        fmt_s.op2     = {XLEN{1'b0}};
        fmt_s.sdata   = {XLEN{1'b0}};
        fmt_s.imm     = {XLEN{1'b0}};
        fmt_s.pc      = in_pc;
        fmt_s.illegal = 1'b0;
        case (opcode_s)
            OP_R: begin
                fmt_s.op1 = rs1_val_s;
                fmt_s.op2 = rs2_val_s;
            end
            OP_B: begin
                fmt_s.op1 = rs1_val_s;
                fmt_s.op2 = rs2_val_s;
                fmt_s.imm = imm_b_s;
            end
            OP_IMM, OP_LOAD: begin
                fmt_s.op1 = rs1_val_s;
                fmt_s.op2 = imm_i_s;
                fmt_s.imm = imm_i_s;
            end
            OP_STORE: begin
                fmt_s.op1   = rs1_val_s;
                fmt_s.op2   = imm_s_s;
                fmt_s.sdata = rs2_val_s;
                fmt_s.imm   = imm_s_s;
            end
            OP_JAL: begin
                fmt_s.op1 = in_pc;
                fmt_s.op2 = XLEN'(32'd4);
                fmt_s.imm = imm_j_s;
            end
            OP_JALR: begin
                fmt_s.op1   = in_pc;
                fmt_s.op2   = XLEN'(32'd4);
                fmt_s.sdata = rs1_val_s;
                fmt_s.imm   = imm_i_s;
            end
            OP_LUI: begin
                fmt_s.op2 = imm_u_s;
                fmt_s.imm = imm_u_s;
            end
            OP_AUIPC: begin
                fmt_s.op1 = in_pc;
                fmt_s.op2 = imm_u_s;
                fmt_s.imm = imm_u_s;
            end
            default: begin
                fmt_s.illegal = 1'b1;
            end
        endcase
    end

    assign accept_s = in_valid & in_ready_r;

    // Skid-buffer next state and register load controls; flush overrides all loads.
    always_comb begin
        state_next_s     = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush) begin
            state_next_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_next_s   = ST_BUSY;
                        load_main_in_s = 1'b1;
                    end else begin
                        state_next_s = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (accept_s && out_ready) begin
                        load_main_in_s = 1'b1;
                    end else if (accept_s) begin
                        state_next_s = ST_FULL;
                        load_skid_s  = 1'b1;
                    end else if (out_ready) begin
                        state_next_s = ST_EMPTY;
                    end else begin
                        state_next_s = ST_BUSY;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        state_next_s     = ST_BUSY;
                        load_main_skid_s = 1'b1;
                    end else begin
                        state_next_s = ST_FULL;
                    end
                end
                default: begin
                    state_next_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State, handshake flags and entry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            main_r      <= '{default: '0};
            skid_r      <= '{default: '0};
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s != ST_FULL);
            out_valid_r <= (state_next_s != ST_EMPTY);
            if (load_main_in_s) begin
                main_r <= fmt_s;
            end else if (load_main_skid_s) begin
                main_r <= skid_r;
            end
            if (load_skid_s) begin
                skid_r <= fmt_s;
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign operand1    = main_r.op1;
    assign operand2    = main_r.op2;
    assign s_data      = main_r.sdata;
    assign imm         = main_r.imm;
    assign out_pc      = main_r.pc;
    assign out_illegal = main_r.illegal;

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: directed vector table, hand-written flow sequences, randomized run vs. a queue model.
module tb_id_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, fwd_valid, flush, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_pc, reg1_data, reg2_data, fwd_data;
    logic [4:0]  fwd_rd;
    logic [31:0] operand1, operand2, s_data, imm, out_pc;

    id_operand_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .reg1_data(reg1_data), .reg2_data(reg2_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .operand1(operand1), .operand2(operand2),
        .s_data(s_data), .imm(imm), .out_pc(out_pc), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op1, op2, sd, imm, pc;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr, pc, r1, r2;
        logic        fv;
        logic [4:0]  frd;
        logic [31:0] fd;
        logic [31:0] op1, op2, sd, imm;
        logic        ill;
    } vec_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_out = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: immediates from arithmetic shifts on the signed word.
    function automatic exp_t ref_entry(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] r1, input logic [31:0] r2,
                                       input logic fv, input logic [4:0] frd, input logic [31:0] fd);
        exp_t e;
        int si, ii, is, ib, iu, ij;
        logic [31:0] a, b;
        si = int'(ins);
        ii = si >>> 20;
        is = ((si >>> 25) * 32) + int'(ins[11:7]);
        ib = ((si >>> 31) * 4096) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        iu = si & 32'hFFFFF000;
        ij = ((si >>> 31) * 1048576) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        a = r1;
        b = r2;
`ifdef ID_OPERAND_FWD_EN
        if (fv && frd != 5'd0 && frd == ins[19:15]) a = fd;
        if (fv && frd != 5'd0 && frd == ins[24:20]) b = fd;
`endif
        e = '{op1: 32'd0, op2: 32'd0, sd: 32'd0, imm: 32'd0, pc: pc, ill: 1'b0};
        case (ins[6:0])
            7'h33:         begin e.op1 = a;  e.op2 = b; end
            7'h63:         begin e.op1 = a;  e.op2 = b; e.imm = ib; end
            7'h13, 7'h03:  begin e.op1 = a;  e.op2 = ii; e.imm = ii; end
            7'h23:         begin e.op1 = a;  e.op2 = is; e.sd = b; e.imm = is; end
            7'h6F:         begin e.op1 = pc; e.op2 = 32'd4; e.imm = ij; end
            7'h67:         begin e.op1 = pc; e.op2 = 32'd4; e.sd = a; e.imm = ii; end
            7'h37:         begin e.op2 = iu; e.imm = iu; end
            7'h17:         begin e.op1 = pc; e.op2 = iu; e.imm = iu; end
            default:       e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // One clock: drive at negedge, update the queue model at posedge, check #1 later.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2, input logic fv,
                         input logic [4:0] frd, input logic [31:0] fd, input logic ordy, input logic fl);
        exp_t e;
        logic acc, pop;
        @(negedge clk);
        in_valid = v; in_instr = ins; in_pc = pc; reg1_data = r1; reg2_data = r2;
        fwd_valid = fv; fwd_rd = frd; fwd_data = fd; out_ready = ordy; flush = fl;
        acc = v && (q.size() < 2);
        pop = (q.size() > 0) && ordy;
        e = ref_entry(ins, pc, r1, r2, fv, frd, fd);
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) begin
                void'(q.pop_front());
                n_out++;
            end
            if (acc) q.push_back(e);
        end
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (q.size() > 0) begin
            chk("operand1", operand1, q[0].op1);
            chk("operand2", operand2, q[0].op2);
            chk("s_data", s_data, q[0].sd);
            chk("imm", imm, q[0].imm);
            chk("out_pc", out_pc, q[0].pc);
            chk("out_illegal", out_illegal, q[0].ill);
        end
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, ordy, 1'b0);
    endtask

    vec_t tbl[12];
    logic [6:0] opcs[10] = '{7'h33, 7'h63, 7'h13, 7'h03, 7'h23, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

    initial begin
        int base;
        logic [31:0] fwd_exp;
        logic [31:0] tmp, ins;
        logic [4:0]  frd;

`ifdef ID_OPERAND_FWD_EN
        fwd_exp = 32'h0000_00AA;
`else
        fwd_exp = 32'h0000_0005;
`endif
        //          instr          pc            r1            r2            fv    frd    fd            op1           op2           sd            imm           ill
        tbl[0]  = '{32'hFFF10093, 32'h0000_0000, 32'h0000_0005, 32'h0,        1'b0, 5'd0, 32'h0,        32'h0000_0005, 32'hFFFF_FFFF, 32'h0,        32'hFFFF_FFFF, 1'b0};
        tbl[1]  = '{32'h00312423, 32'h0000_0010, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0,        32'h0000_1000, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0000_0008, 1'b0};
        tbl[2]  = '{32'h123452B7, 32'h0000_0020, 32'h1111_1111, 32'h2222_2222, 1'b0, 5'd0, 32'h0,        32'h0,         32'h1234_5000, 32'h0,        32'h1234_5000, 1'b0};
        tbl[3]  = '{32'h010000EF, 32'h0000_0100, 32'h1111_1111, 32'h2222_2222, 1'b0, 5'd0, 32'h0,        32'h0000_0100, 32'h0000_0004, 32'h0,        32'h0000_0010, 1'b0};
        tbl[4]  = '{32'hFFFFFFFF, 32'h0000_0200, 32'h1111_1111, 32'h2222_2222, 1'b0, 5'd0, 32'h0,        32'h0,         32'h0,         32'h0,        32'h0,         1'b1};
        tbl[5]  = '{32'h002081B3, 32'h0000_0204, 32'h0000_0007, 32'h0000_0009, 1'b0, 5'd0, 32'h0,        32'h0000_0007, 32'h0000_0009, 32'h0,        32'h0,         1'b0};
        tbl[6]  = '{32'hFE208EE3, 32'h0000_0208, 32'h0000_0003, 32'h0000_0004, 1'b0, 5'd0, 32'h0,        32'h0000_0003, 32'h0000_0004, 32'h0,        32'hFFFF_FFFC, 1'b0};
        tbl[7]  = '{32'hFFFFF097, 32'h0000_2000, 32'h1111_1111, 32'h2222_2222, 1'b0, 5'd0, 32'h0,        32'h0000_2000, 32'hFFFF_F000, 32'h0,        32'hFFFF_F000, 1'b0};
        tbl[8]  = '{32'hFF8280E7, 32'h0000_0300, 32'h0000_4000, 32'h2222_2222, 1'b0, 5'd0, 32'h0,        32'h0000_0300, 32'h0000_0004, 32'h0000_4000, 32'hFFFF_FFF8, 1'b0};
        tbl[9]  = '{32'hFFF12083, 32'h0000_0304, 32'h0000_0040, 32'h2222_2222, 1'b0, 5'd0, 32'h0,        32'h0000_0040, 32'hFFFF_FFFF, 32'h0,        32'hFFFF_FFFF, 1'b0};
        tbl[10] = '{32'hFFF10093, 32'h0000_0308, 32'h0000_0005, 32'h0,        1'b1, 5'd2, 32'h0000_00AA, fwd_exp,     32'hFFFF_FFFF, 32'h0,        32'hFFFF_FFFF, 1'b0};
        tbl[11] = '{32'h00300093, 32'h0000_030C, 32'h0000_0055, 32'h0,        1'b1, 5'd0, 32'h0000_00BB, 32'h0000_0055, 32'h0000_0003, 32'h0,        32'h0000_0003, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0; reg1_data = 32'h0;
        reg2_data = 32'h0; fwd_valid = 1'b0; fwd_rd = 5'd0; fwd_data = 32'h0; out_ready = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst in_ready", in_ready, 1'b1);
        chk("rst operand1", operand1, 32'h0);
        chk("rst operand2", operand2, 32'h0);
        chk("rst s_data", s_data, 32'h0);
        chk("rst imm", imm, 32'h0);
        chk("rst out_pc", out_pc, 32'h0);
        chk("rst illegal", out_illegal, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: single transfers against hand-derived constants.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, tbl[i].instr, tbl[i].pc, tbl[i].r1, tbl[i].r2, tbl[i].fv, tbl[i].frd, tbl[i].fd, 1'b1, 1'b0);
            chk($sformatf("tbl%0d valid", i), out_valid, 1'b1);
            chk($sformatf("tbl%0d op1", i), operand1, tbl[i].op1);
            chk($sformatf("tbl%0d op2", i), operand2, tbl[i].op2);
            chk($sformatf("tbl%0d sdata", i), s_data, tbl[i].sd);
            chk($sformatf("tbl%0d imm", i), imm, tbl[i].imm);
            chk($sformatf("tbl%0d pc", i), out_pc, tbl[i].pc);
            chk($sformatf("tbl%0d illegal", i), out_illegal, tbl[i].ill);
            idle(1'b1);
        end

        // Back-pressure: three back-to-back inputs while EX stalls; third must be refused.
        base = n_out;
        cycle(1'b1, 32'h00100093, 32'h400, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200093, 32'h404, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h00300093, 32'h408, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk("bp in_ready low", in_ready, 1'b0);
        chk("bp head pc", out_pc, 32'h400);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        chk("bp second pc", out_pc, 32'h404);
        repeat (3) idle(1'b1);
        chk("bp drained count", n_out - base, 32'd2);

        // Flush while FULL with a new input offered: nothing survives.
        cycle(1'b1, 32'h00500093, 32'h500, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h00600093, 32'h504, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk("pre-flush in_ready", in_ready, 1'b0);
        cycle(1'b1, 32'h00700093, 32'h508, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        chk("flush out_valid", out_valid, 1'b0);
        chk("flush in_ready", in_ready, 1'b1);
        repeat (2) idle(1'b1);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            tmp = $urandom();
            ins = {tmp[31:7], opcs[$urandom_range(0, 9)]};
            if ($urandom_range(0, 3) == 0) frd = ins[19:15];
            else if ($urandom_range(0, 2) == 0) frd = ins[24:20];
            else frd = 5'($urandom_range(0, 31));
            cycle(1'($urandom_range(0, 3) != 0), ins, $urandom(), $urandom(), $urandom(),
                  1'($urandom_range(0, 1)), frd, $urandom(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
        end
        repeat (3) idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/id_operand_stage.md
# id_operand_stage

Registered ID-stage operand formatter between the register-file read and EX. It decodes the immediate for every RV32I format, selects ALU operand1/operand2 and store data for all base opcodes (including JAL, JALR, LUI, AUIPC), and flags illegal opcodes. Results are held in a two-entry skid buffer with valid/ready handshakes on both sides, so EX back-pressure never combinationally reaches IF/ID.

## Interface
- XLEN, 32: datapath width, 32 or 64; immediates sign-extended to XLEN.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream holds a decoded instruction.
- in_ready  out  1  stage can accept; registered.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  instruction address.
- reg1_data, reg2_data  in  XLEN  register-file read data for rs1/rs2.
- fwd_valid  in  1  EX/MEM result valid for forwarding.
- fwd_rd  in  5  destination of the forwarded result.
- fwd_data  in  XLEN  forwarded result.
- flush  in  1  kill all held and incoming entries.
- out_valid  out  1  output entry valid.
- out_ready  in  1  EX accepts the entry.
- operand1, operand2, s_data, imm  out  XLEN  ALU operands, store data, decoded immediate.
- out_pc  out  XLEN  pc of the entry.
- out_illegal  out  1  opcode not recognised.

## Operation
- opcode = in_instr[6:0]; immediates: I, S, B (bit0 = 0), U (low 12 bits = 0), J (bit0 = 0), all sign-extended to XLEN.
- R (0110011), B (1100011): op1 = rs1, op2 = rs2, s_data = 0, imm = 0 for R and B-imm for B.
- I_IMM (0010011), LOAD (0000011): op1 = rs1, op2 = I-imm, s_data = 0.
- S (0100011): op1 = rs1, op2 = S-imm, s_data = rs2.
- JAL (1101111): op1 = pc, op2 = 4, imm = J-imm.
- JALR (1100111): op1 = pc, op2 = 4, imm = I-imm, s_data = rs1 (jump base).
- LUI (0110111): op1 = 0, op2 = U-imm. AUIPC (0010111): op1 = pc, op2 = U-imm.
- Any other opcode: all data outputs 0, out_illegal = 1. The entry still flows through the handshake.
- rs1/rs2 values come from reg1_data/reg2_data, subject to forwarding (see Configuration).
- Skid buffer states:
  - EMPTY: out_valid = 0.
  - BUSY: main register valid.
  - FULL: main and skid registers valid.
- Transitions:
  - EMPTY accept → BUSY.
  - BUSY accept with out_ready → BUSY, main reloaded.
  - BUSY accept without out_ready → FULL, entry into skid.
  - BUSY out_ready with no accept → EMPTY.
  - FULL out_ready → BUSY, skid moves to main.
- in_ready = (state != FULL), registered. Accept = in_valid & in_ready.
- flush has priority over everything: next state EMPTY, and any entry accepted in the flush cycle is discarded.

## Timing
- Latency: 1 cycle from accept to out_valid. Throughput is 1 per cycle while out_ready = 1.
- Output fields are stable while out_valid & !out_ready.
- Reset (asynchronous, rst_n = 0): state EMPTY, out_valid = 0, in_ready = 1.
- Also on reset: operand1, operand2, s_data, imm, out_pc = 0 and out_illegal = 0.
- Deassert rst_n synchronously to clk. Reset mid-transfer drops all entries.
- in_ready falls in the cycle after entering FULL and rises the cycle after leaving it.
- Upstream must not depend on a combinational in_ready.

## Configuration
- Macro `ID_OPERAND_FWD_EN`.
- Defined: when fwd_valid and fwd_rd != 0 and fwd_rd equals rs1 (in_instr[19:15]), fwd_data replaces reg1_data. The same rule applies for rs2 (in_instr[24:20]). Substitution happens before operand selection.
- Not defined: fwd_* ports are present but ignored, and register-file data is used unchanged.

## Test plan
- Reset: hold rst_n = 0 → out_valid = 0, in_ready = 1, all data outputs 0.
- Format coverage:
  - addi x1,x2,-1 (0xFFF10093), reg1 = 5 → op1 = 5, op2 = 0xFFFFFFFF.
  - sw x3,8(x2) → op2 = 8, s_data = reg2.
  - lui 0x12345 → op2 = 0x12345000.
  - jal pc = 0x100 → op1 = 0x100, op2 = 4.
- Illegal: opcode 0x7F → out_illegal = 1, operands 0, entry still handshaken.
- Back-pressure:
  - out_ready = 0 with 3 back-to-back valid inputs → first two held (BUSY then FULL), in_ready = 0, third not accepted.
  - Then out_ready = 1 → entries emerge in order, no loss or duplication.
- Flush in FULL with in_valid = 1 → next cycle out_valid = 0, in_ready = 1, flushed entries never appear.
- With `ID_OPERAND_FWD_EN`:
  - fwd_rd = 2, fwd_data = 0xAA, rs1 = x2 → op1 = 0xAA.
  - fwd_rd = 0 → no substitution.
  - Without the macro, op1 = reg1_data.
